// File: rtl/param_tiny_pkg.sv
//------------------------------------------------------------------------------
// Module   : param_tiny_pkg
// Brief    : Opcodes, FSM state encoding and decode record for the tiny CPU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package param_tiny_pkg;

    localparam logic [3:0] c_OP_MOV_A_IM = 4'b0000;
    localparam logic [3:0] c_OP_MOV_B_IM = 4'b0001;
    localparam logic [3:0] c_OP_MOV_A_B  = 4'b0010;
    localparam logic [3:0] c_OP_MOV_B_A  = 4'b0011;
    localparam logic [3:0] c_OP_ADD_A_IM = 4'b0100;
    localparam logic [3:0] c_OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] c_OP_IN_A     = 4'b0110;
    localparam logic [3:0] c_OP_IN_B     = 4'b0111;
    localparam logic [3:0] c_OP_OUT_IM   = 4'b1000;
    localparam logic [3:0] c_OP_OUT_B    = 4'b1001;
    localparam logic [3:0] c_OP_JMP      = 4'b1010;
    localparam logic [3:0] c_OP_JNC      = 4'b1011;
    localparam logic [3:0] c_OP_HLT      = 4'b1111;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_DECODE = 3'd2;
    localparam logic [2:0] c_S_SELECT = 3'd3;
    localparam logic [2:0] c_S_EXEC   = 3'd4;
    localparam logic [2:0] c_S_WB     = 3'd5;
    localparam logic [2:0] c_S_HALT   = 3'd6;

    localparam logic [1:0] c_SEL_A    = 2'd0;
    localparam logic [1:0] c_SEL_B    = 2'd1;
    localparam logic [1:0] c_SEL_GPIO = 2'd2;
    localparam logic [1:0] c_SEL_ZERO = 2'd3;

    typedef struct packed {
        logic       wr_a;
        logic       wr_b;
        logic       wr_out;
        logic       jump_en;
        logic [1:0] sel;
        logic       is_halt;
    } decode_t;

endpackage

`default_nettype wire

// File: rtl/ptp_inst_decoder.sv
//------------------------------------------------------------------------------
// Module   : ptp_inst_decoder
// Brief    : Combinational opcode decode into write enables, jump and operand select.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ptp_inst_decoder
    import param_tiny_pkg::*;
(
    input  logic [3:0] inst,
    input  logic       cf,
    output logic [2:0] wr_en,   // {out, b, a}
    output logic       jump_en,
    output logic [1:0] sel,
    output logic       is_halt
);

    always_comb begin
        wr_en   = 3'b000;
        jump_en = 1'b0;
        sel     = c_SEL_ZERO;
        is_halt = 1'b0;
        case (inst)
            c_OP_MOV_A_IM: wr_en = 3'b001;
            c_OP_MOV_B_IM: wr_en = 3'b010;
            c_OP_MOV_A_B:  begin wr_en = 3'b001; sel = c_SEL_B;    end
            c_OP_MOV_B_A:  begin wr_en = 3'b010; sel = c_SEL_A;    end
            c_OP_ADD_A_IM: begin wr_en = 3'b001; sel = c_SEL_A;    end
            c_OP_ADD_B_IM: begin wr_en = 3'b010; sel = c_SEL_B;    end
            c_OP_IN_A:     begin wr_en = 3'b001; sel = c_SEL_GPIO; end
            c_OP_IN_B:     begin wr_en = 3'b010; sel = c_SEL_GPIO; end
            c_OP_OUT_IM:   wr_en = 3'b100;
            c_OP_OUT_B:    begin wr_en = 3'b100; sel = c_SEL_B;    end
            c_OP_JMP:      jump_en = 1'b1;
            c_OP_JNC:      jump_en = ~cf;
            c_OP_HLT:      is_halt = 1'b1;
            default:       ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/param_tiny_processor.sv
//------------------------------------------------------------------------------
// Module   : param_tiny_processor
// Brief    : Five-cycle multi-state accumulator CPU with GPIO and loadable program RAM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_tiny_processor
    import param_tiny_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic                clock,
    input  logic                reset_p,
    input  logic                run,
    input  logic [DATA_W-1:0]   gpio_in,
    output logic [DATA_W-1:0]   gpio_out,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [DATA_W+3:0]   prog_data,
    output logic [PC_W-1:0]     pc,
    output logic                retire,
    output logic                halted
);

    localparam int              c_DEPTH  = 2**PC_W;
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [DATA_W+3:0] r_mem [c_DEPTH];

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_inst;
    logic [DATA_W-1:0] r_imm;
    decode_t           r_dec;
    logic [DATA_W-1:0] r_sel_val;
    logic [DATA_W-1:0] r_result;
    logic              r_cf;
    logic [DATA_W-1:0] r_rega;
    logic [DATA_W-1:0] r_regb;
    logic [DATA_W-1:0] r_gpio_out;
    logic              r_retire;
    logic              r_halted;

    logic [2:0]        w_wr_en;
    logic              w_jump_en;
    logic [1:0]        w_sel;
    logic              w_is_halt;
    logic [DATA_W+3:0] w_fetch_word;
    logic [DATA_W-1:0] w_sel_val;
    logic [DATA_W:0]   w_sum;
    logic [PC_W-1:0]   w_jump_pc;
    logic              w_prog_ok;

    ptp_inst_decoder u_dec (
        .inst    (r_inst),
        .cf      (r_cf),
        .wr_en   (w_wr_en),
        .jump_en (w_jump_en),
        .sel     (w_sel),
        .is_halt (w_is_halt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (run) w_state_nxt = c_S_FETCH;
            c_S_FETCH:  w_state_nxt = c_S_DECODE;
            c_S_DECODE: w_state_nxt = c_S_SELECT;
            c_S_SELECT: w_state_nxt = c_S_EXEC;
            c_S_EXEC:   w_state_nxt = c_S_WB;
            c_S_WB: begin
                if (r_dec.is_halt) w_state_nxt = c_S_HALT;
                else if (run)      w_state_nxt = c_S_FETCH;
                else               w_state_nxt = c_S_IDLE;
            end
            c_S_HALT:   if (!run) w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_val = '0;
        case (r_dec.sel)
            c_SEL_A:    w_sel_val = r_rega;
            c_SEL_B:    w_sel_val = r_regb;
            c_SEL_GPIO: w_sel_val = gpio_in;
            default:    w_sel_val = '0;
        endcase
    end

    assign w_fetch_word = r_mem[r_pc];
    assign w_sum        = {1'b0, r_sel_val} + {1'b0, r_imm};
    assign w_prog_ok    = (r_state == c_S_IDLE) || (r_state == c_S_HALT);

    // Jump target is the ALU result fitted to the PC width.
    generate
        if (PC_W > DATA_W) begin : g_jump_ext
            assign w_jump_pc = {{(PC_W-DATA_W){1'b0}}, r_result};
        end else begin : g_jump_trunc
            assign w_jump_pc = r_result[PC_W-1:0];
        end
    endgenerate

    // Program RAM is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge clock) begin
        if (!reset_p && prog_we && w_prog_ok) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_p) begin
            r_state    <= c_S_IDLE;
            r_pc       <= '0;
            r_inst     <= '0;
            r_imm      <= '0;
            r_dec      <= '0;
            r_sel_val  <= '0;
            r_result   <= '0;
            r_cf       <= 1'b0;
            r_rega     <= '0;
            r_regb     <= '0;
            r_gpio_out <= '0;
            r_retire   <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_retire <= (r_state == c_S_WB);
            r_halted <= (w_state_nxt == c_S_HALT);
            case (r_state)
                c_S_FETCH: begin
                    r_inst <= w_fetch_word[DATA_W+3:DATA_W];
                    r_imm  <= w_fetch_word[DATA_W-1:0];
                end
                c_S_DECODE: begin
                    r_dec.wr_a    <= w_wr_en[0];
                    r_dec.wr_b    <= w_wr_en[1];
                    r_dec.wr_out  <= w_wr_en[2];
                    r_dec.jump_en <= w_jump_en;
                    r_dec.sel     <= w_sel;
                    r_dec.is_halt <= w_is_halt;
                end
                c_S_SELECT: r_sel_val <= w_sel_val;
                c_S_EXEC: begin
                    r_result <= w_sum[DATA_W-1:0];
                    r_cf     <= w_sum[DATA_W];
                end
                c_S_WB: begin
                    if (r_dec.wr_a)   r_rega     <= r_result;
                    if (r_dec.wr_b)   r_regb     <= r_result;
                    if (r_dec.wr_out) r_gpio_out <= r_result;
                    // HLT leaves the PC pointing at itself.
                    if (r_dec.jump_en)       r_pc <= w_jump_pc;
                    else if (!r_dec.is_halt) r_pc <= r_pc + c_PC_ONE;
                end
                default: ;
            endcase
        end
    end

    assign gpio_out = r_gpio_out;
    assign pc       = r_pc;
    assign retire   = r_retire;
    assign halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_param_tiny_processor.sv
//------------------------------------------------------------------------------
// Module   : tb_param_tiny_processor
// Brief    : Directed self-checking bench; default instance plus an 8-bit/6-bit PC instance.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_tiny_processor;

    logic       clock = 1'b0;
    logic       reset_p, run, prog_we;
    logic [3:0] gpio_in, gpio_out, prog_addr, pc;
    logic [7:0] prog_data;
    logic       retire, halted;

    logic        reset_p1, run1, prog_we1;
    logic [7:0]  gpio_in1, gpio_out1;
    logic [5:0]  prog_addr1, pc1;
    logic [11:0] prog_data1;
    logic        retire1, halted1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    param_tiny_processor u_dut (
        .clock(clock), .reset_p(reset_p), .run(run), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc(pc), .retire(retire), .halted(halted)
    );

    param_tiny_processor #(.DATA_W(8), .PC_W(6)) u_dut_wide (
        .clock(clock), .reset_p(reset_p1), .run(run1), .gpio_in(gpio_in1),
        .gpio_out(gpio_out1), .prog_we(prog_we1), .prog_addr(prog_addr1),
        .prog_data(prog_data1), .pc(pc1), .retire(retire1), .halted(halted1)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick(1);
        prog_we = 1'b0;
    endtask

    task automatic do_reset;
        run = 1'b0; reset_p = 1'b1;
        tick(1);
        reset_p = 1'b0;
    endtask

    task automatic test_reset;
        reset_p = 1'b1; run = 1'b1; reset_p1 = 1'b1;
        tick(2);
        reset_p = 1'b0; run = 1'b0; reset_p1 = 1'b0;
        checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL reset_gpio: got %h want 0", gpio_out); end
        checks++; if ({retire, halted} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {retire, halted}); end
        checks++; if ({pc1, gpio_out1} !== 14'h0) begin errors++; $display("FAIL reset_wide: got pc=%h out=%h want 0", pc1, gpio_out1); end
    endtask

    task automatic test_led_blink;
        logic [3:0] exp_out [4];
        exp_out = '{4'h1, 4'h2, 4'h4, 4'h8};
        do_reset();
        load(4'd0, 8'h81); load(4'd1, 8'h82); load(4'd2, 8'h84);
        load(4'd3, 8'h88); load(4'd4, 8'hA0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? 5 : 4);
            checks++; if (retire !== 1'b0) begin errors++; $display("FAIL blink_gap%0d: retire got %b want 0", i, retire); end
            tick(1);
            checks++;
            if (retire !== 1'b1 || gpio_out !== exp_out[i] || pc !== 4'(i + 1)) begin
                errors++;
                $display("FAIL blink_step%0d: got retire=%b out=%h pc=%h want 1 %h %h", i, retire, gpio_out, pc, exp_out[i], 4'(i + 1));
            end
        end
        tick(5);
        checks++; if (pc !== 4'h0 || gpio_out !== 4'h8) begin errors++; $display("FAIL blink_jmp: got pc=%h out=%h want 0 8", pc, gpio_out); end
        tick(5);
        checks++; if (pc !== 4'h1 || gpio_out !== 4'h1) begin errors++; $display("FAIL blink_repeat: got pc=%h out=%h want 1 1", pc, gpio_out); end
        run = 1'b0;
        tick(5);
        checks++; if (retire !== 1'b1 || pc !== 4'h2 || gpio_out !== 4'h2) begin errors++; $display("FAIL blink_stop_completes: got retire=%b pc=%h out=%h want 1 2 2", retire, pc, gpio_out); end
        tick(5);
        checks++; if (retire !== 1'b0 || pc !== 4'h2) begin errors++; $display("FAIL blink_idle: got retire=%b pc=%h want 0 2", retire, pc); end
    endtask

    task automatic test_carry;
        do_reset();
        load(4'd0, 8'h0F); load(4'd1, 8'h41); load(4'd2, 8'hB5); load(4'd3, 8'hF0);
        run = 1'b1;
        tick(6);
        checks++; if (pc !== 4'h1) begin errors++; $display("FAIL carry_pc1: got %h want 1", pc); end
        tick(10);
        checks++; if (pc !== 4'h3) begin errors++; $display("FAIL carry_jnc_not_taken: got pc=%h want 3", pc); end
        tick(5);
        checks++; if (halted !== 1'b1 || pc !== 4'h3) begin errors++; $display("FAIL carry_halt: got halted=%b pc=%h want 1 3", halted, pc); end
        run = 1'b0;
        tick(1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL carry_exit_halt: got %b want 0", halted); end
    endtask

    task automatic test_jnc_taken;
        do_reset();
        load(4'd0, 8'h01); load(4'd1, 8'hB3); load(4'd2, 8'h8F); load(4'd3, 8'hF0);
        run = 1'b1;
        tick(11);
        checks++; if (pc !== 4'h3) begin errors++; $display("FAIL jnc_taken_pc: got %h want 3", pc); end
        tick(5);
        checks++; if (halted !== 1'b1 || gpio_out !== 4'h0) begin errors++; $display("FAIL jnc_skip: got halted=%b out=%h want 1 0", halted, gpio_out); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_input;
        do_reset();
        gpio_in = 4'h9;
        load(4'd0, 8'h61); load(4'd1, 8'h30); load(4'd2, 8'h90); load(4'd3, 8'hF0);
        run = 1'b1;
        tick(11);
        checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL input_early: got %h want 0", gpio_out); end
        tick(5);
        checks++; if (retire !== 1'b1 || gpio_out !== 4'hA) begin errors++; $display("FAIL input_out: got retire=%b out=%h want 1 a", retire, gpio_out); end
        tick(5);
        run = 1'b0; gpio_in = 4'h0;
        tick(1);
    endtask

    task automatic test_halt_load;
        do_reset();
        load(4'd0, 8'hF0);
        run = 1'b1;
        tick(5);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", halted); end
        tick(1);
        checks++; if (halted !== 1'b1 || pc !== 4'h0) begin errors++; $display("FAIL halt_cycle6: got halted=%b pc=%h want 1 0", halted, pc); end
        tick(3);
        checks++; if (halted !== 1'b1 || pc !== 4'h0) begin errors++; $display("FAIL halt_hold: got halted=%b pc=%h want 1 0", halted, pc); end
        load(4'd0, 8'h83); load(4'd1, 8'hF0);
        run = 1'b0;
        tick(1);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_to_idle: got %b want 0", halted); end
        run = 1'b1;
        tick(4);
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h8F;
        tick(1);
        prog_we = 1'b0;
        tick(1);
        checks++; if (retire !== 1'b1 || gpio_out !== 4'h3 || pc !== 4'h1) begin errors++; $display("FAIL halt_loaded_prog: got retire=%b out=%h pc=%h want 1 3 1", retire, gpio_out, pc); end
        tick(5);
        checks++; if (halted !== 1'b1 || gpio_out !== 4'h3) begin errors++; $display("FAIL exec_write_ignored: got halted=%b out=%h want 1 3", halted, gpio_out); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_exec;
        do_reset();
        run = 1'b1;
        tick(6);
        checks++; if (gpio_out !== 4'h3 || pc !== 4'h1) begin errors++; $display("FAIL mid_pre: got out=%h pc=%h want 3 1", gpio_out, pc); end
        tick(3);
        reset_p = 1'b1;
        tick(1);
        reset_p = 1'b0; run = 1'b0;
        checks++; if ({pc, gpio_out, retire, halted} !== 10'h0) begin errors++; $display("FAIL mid_reset: got pc=%h out=%h retire=%b halted=%b want all 0", pc, gpio_out, retire, halted); end
        tick(5);
        checks++; if (halted !== 1'b0 || pc !== 4'h0) begin errors++; $display("FAIL mid_stays_idle: got halted=%b pc=%h want 0 0", halted, pc); end
        reset_p = 1'b1; run = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h8C;
        tick(1);
        reset_p = 1'b0; prog_we = 1'b0;
        tick(5);
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_prio_run: retire got %b want 0", retire); end
        tick(1);
        checks++; if (retire !== 1'b1 || gpio_out !== 4'h3 || pc !== 4'h1) begin errors++; $display("FAIL reset_prio_we: got retire=%b out=%h pc=%h want 1 3 1", retire, gpio_out, pc); end
        tick(5);
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_wide;
        logic [5:0]  a [7];
        logic [11:0] d [7];
        a = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd63};
        d = '{12'h001, 12'h4FF, 12'hB10, 12'h300, 12'h955, 12'hA3F, 12'hC00};
        for (int i = 0; i < 7; i++) begin
            prog_we1 = 1'b1; prog_addr1 = a[i]; prog_data1 = d[i];
            tick(1);
        end
        prog_we1 = 1'b0; run1 = 1'b1;
        tick(6);
        checks++; if (pc1 !== 6'd1) begin errors++; $display("FAIL wide_pc1: got %0d want 1", pc1); end
        tick(10);
        checks++; if (pc1 !== 6'd3) begin errors++; $display("FAIL wide_carry_jnc: got pc=%0d want 3", pc1); end
        tick(10);
        checks++; if (gpio_out1 !== 8'h55 || pc1 !== 6'd5) begin errors++; $display("FAIL wide_a_zero: got out=%h pc=%0d want 55 5", gpio_out1, pc1); end
        tick(5);
        checks++; if (pc1 !== 6'd63) begin errors++; $display("FAIL wide_jmp: got pc=%0d want 63", pc1); end
        tick(5);
        checks++; if (pc1 !== 6'd0 || retire1 !== 1'b1) begin errors++; $display("FAIL wide_wrap: got pc=%0d retire=%b want 0 1", pc1, retire1); end
        run1 = 1'b0;
        tick(6);
    endtask

    initial begin
        reset_p = 1'b1; run = 1'b0; prog_we = 1'b0; gpio_in = '0; prog_addr = '0; prog_data = '0;
        reset_p1 = 1'b1; run1 = 1'b0; prog_we1 = 1'b0; gpio_in1 = '0; prog_addr1 = '0; prog_data1 = '0;
        test_reset();
        test_led_blink();
        test_carry();
        test_jnc_taken();
        test_input();
        test_halt_load();
        test_reset_mid_exec();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
